// File: rtl/id_imm_decode_stage_pkg.sv
// id_pkg: shared opcodes, ALU codes, FSM state codes and control-word packing for id_imm_decode_stage.
// Revision 1.0
`default_nettype none

package id_pkg;

  typedef enum logic [2:0] {
    OP_NOP  = 3'b000,
    OP_ADDI = 3'b001,
    OP_SUBI = 3'b010,
    OP_ANDI = 3'b011,
    OP_PFX  = 3'b100,
    OP_ORI  = 3'b101,
    OP_XORI = 3'b110,
    OP_ILL  = 3'b111
  } op_e;

  localparam logic [5:0] ALU_NOP  = 6'b000000;
  localparam logic [5:0] ALU_ADDI = 6'b101001;
  localparam logic [5:0] ALU_SUBI = 6'b101101;
  localparam logic [5:0] ALU_ANDI = 6'b010001;
  localparam logic [5:0] ALU_ORI  = 6'b011101;
  localparam logic [5:0] ALU_XORI = 6'b001101;

  localparam logic [6:0] MISC_ALU = 7'b0000100;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_PFX  = 1'b1;

  // Packs {alu, dst, src, misc} into the low 13+2*aw bits; register fields are aw bits wide.
  function automatic logic [63:0] cw_pack(input logic [5:0] alu, input logic [15:0] dst,
                                          input logic [15:0] src, input logic [6:0] misc,
                                          input int aw);
    logic [63:0] r;
    r = 64'(alu);
    r = (r << aw) | 64'(dst);
    r = (r << aw) | 64'(src);
    r = (r << 7) | 64'(misc);
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_imm_decode_stage_if.sv
// id_if: instruction-in / control-word-out handshake bundle of the immediate decode stage.
// Revision 1.0
`default_nettype none

interface id_if #(
  parameter int REG_AW = 3,
  parameter int IMM_W  = 8,
  parameter int DATA_W = 16
);
  localparam int IW   = 3 + REG_AW + IMM_W;
  localparam int CW_W = 13 + 2 * REG_AW;

  logic              in_valid;
  logic              in_ready;
  logic [IW-1:0]     instr;
  logic              out_valid;
  logic              out_ready;
  logic [CW_W-1:0]   cw_out;
  logic [DATA_W-1:0] lit_out;
  logic              illegal_out;

  modport master (
    output in_valid, instr, out_ready,
    input  in_ready, out_valid, cw_out, lit_out, illegal_out
  );

  modport slave (
    input  in_valid, instr, out_ready,
    output in_ready, out_valid, cw_out, lit_out, illegal_out
  );
endinterface

`default_nettype wire

// File: rtl/id_imm_decode_stage_comb.sv
// id_imm_decode_comb: combinational opcode classifier feeding the decode stage.
// Revision 1.0
`default_nettype none

module id_imm_decode_comb
  import id_pkg::*;
#(
  parameter bit PFX_EN = 1'b1
) (
  input  logic [2:0] op,
  output logic [5:0] alu,
  output logic [6:0] misc,
  output logic       is_alu,
  output logic       is_nop,
  output logic       is_prefix,
  output logic       is_illegal
);

  always_comb begin
    alu        = ALU_NOP;
    misc       = 7'b0;
    is_alu     = 1'b0;
    is_nop     = 1'b0;
    is_prefix  = 1'b0;
    is_illegal = 1'b0;
    case (op_e'(op))
      OP_NOP:  is_nop = 1'b1;
      OP_ADDI: begin alu = ALU_ADDI; misc = MISC_ALU; is_alu = 1'b1; end
      OP_SUBI: begin alu = ALU_SUBI; misc = MISC_ALU; is_alu = 1'b1; end
      OP_ANDI: begin alu = ALU_ANDI; misc = MISC_ALU; is_alu = 1'b1; end
      OP_ORI:  begin alu = ALU_ORI;  misc = MISC_ALU; is_alu = 1'b1; end
      OP_XORI: begin alu = ALU_XORI; misc = MISC_ALU; is_alu = 1'b1; end
      // With no room for upper literal bits a PREFIX has no meaning.
      OP_PFX: begin
        if (PFX_EN) is_prefix = 1'b1;
        else        is_illegal = 1'b1;
      end
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/id_imm_decode_stage.sv
// id_imm_decode_stage: registered, handshaked immediate-ALU decode with PREFIX literal extension.
// Revision 1.0
`default_nettype none

module id_imm_decode_stage
  import id_pkg::*;
#(
  parameter int REG_AW   = 3,
  parameter int IMM_W    = 8,
  parameter int DATA_W   = 16,
  parameter int SIGN_EXT = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  id_if.slave              bus,
  output logic             prefix_pending,
  output logic [CNT_W-1:0] illegal_cnt
);

  localparam int IW   = 3 + REG_AW + IMM_W;
  localparam int CW_W = 13 + 2 * REG_AW;
  localparam int PW   = DATA_W - IMM_W;
  localparam int PW_R = (PW > 0) ? PW : 1;

  logic [2:0]        w_op;
  logic [REG_AW-1:0] w_reg;
  logic [IMM_W-1:0]  w_imm;
  logic [5:0]        w_alu;
  logic [6:0]        w_misc;
  logic              w_is_alu, w_is_nop, w_is_prefix, w_is_illegal;
  logic              w_accept, w_sext;
  logic [DATA_W-1:0] w_pfx_lit, w_ext_lit, w_lit;
  logic [PW_R-1:0]   w_pfx_next;
  logic [CW_W-1:0]   w_cw;
  logic [0:0]        r_state, w_state_nxt;
  logic [PW_R-1:0]   r_pfx;

  assign w_op  = bus.instr[IW-1 -: 3];
  assign w_reg = bus.instr[IMM_W +: REG_AW];
  assign w_imm = bus.instr[IMM_W-1:0];

  id_imm_decode_comb #(.PFX_EN(PW > 0)) u_comb (
    .op         (w_op),
    .alu        (w_alu),
    .misc       (w_misc),
    .is_alu     (w_is_alu),
    .is_nop     (w_is_nop),
    .is_prefix  (w_is_prefix),
    .is_illegal (w_is_illegal)
  );

  assign bus.in_ready   = !bus.out_valid || bus.out_ready;
  assign w_accept       = bus.in_valid && bus.in_ready && !flush;
  assign w_sext         = (SIGN_EXT != 0) && ((w_op == OP_ADDI) || (w_op == OP_SUBI));
  assign prefix_pending = (r_state == ST_PFX);

  generate
    if (PW > 0) begin : g_pfx
      // The low PW bits of {reg, imm} are simply the low PW bits of the instruction.
      assign w_pfx_next = bus.instr[PW-1:0];
      assign w_pfx_lit  = {r_pfx, w_imm};
      assign w_ext_lit  = w_sext ? {{PW{w_imm[IMM_W-1]}}, w_imm} : {{PW{1'b0}}, w_imm};
    end else begin : g_no_pfx
      assign w_pfx_next = '0;
      assign w_pfx_lit  = w_imm;
      assign w_ext_lit  = w_imm;
    end
  endgenerate

  always_comb begin
    w_cw  = '0;
    w_lit = '0;
    if (w_is_alu) begin
      w_cw  = CW_W'(cw_pack(w_alu, 16'(w_reg), 16'(w_reg), w_misc, REG_AW));
      w_lit = (r_state == ST_PFX) ? w_pfx_lit : w_ext_lit;
    end else if (w_is_nop) begin
      w_lit = '1;
    end
  end

  // NOP leaves a pending prefix in place; ALU ops consume it, illegal ops discard it.
  always_comb begin
    w_state_nxt = r_state;
    if (w_is_prefix)                    w_state_nxt = ST_PFX;
    else if (w_is_alu || w_is_illegal)  w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_pfx           <= '0;
      bus.out_valid   <= 1'b0;
      bus.cw_out      <= '0;
      bus.lit_out     <= '0;
      bus.illegal_out <= 1'b0;
    end else if (flush) begin
      r_state         <= ST_IDLE;
      r_pfx           <= '0;
      bus.out_valid   <= 1'b0;
      bus.illegal_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_state <= w_state_nxt;
        if (w_is_prefix) r_pfx <= w_pfx_next;
      end
      if (w_accept && !w_is_prefix) begin
        bus.out_valid   <= 1'b1;
        bus.cw_out      <= w_cw;
        bus.lit_out     <= w_lit;
        bus.illegal_out <= w_is_illegal;
      end else if (bus.out_ready) begin
        bus.out_valid   <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_cnt <= '0;
    end else if (w_accept && w_is_illegal && (illegal_cnt != {CNT_W{1'b1}})) begin
      illegal_cnt <= illegal_cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_id_imm_decode_stage.sv
// tb_id_imm_decode_stage: directed vectors with a queued scoreboard checked by a separate monitor.
// Revision 1.0
`default_nettype none

module tb_id_imm_decode_stage;
  import id_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       pp, pp2;
  logic [7:0] cnt, cnt2;

  always #5 clk = ~clk;

  id_if bus ();
  id_if bus2 ();

  id_imm_decode_stage #(.SIGN_EXT(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
    .prefix_pending(pp), .illegal_cnt(cnt)
  );

  id_imm_decode_stage #(.SIGN_EXT(1)) dut_sx (
    .clk(clk), .rst_n(rst_n), .flush(1'b0), .bus(bus2),
    .prefix_pending(pp2), .illegal_cnt(cnt2)
  );

  typedef struct {
    logic [18:0] cw;
    logic [15:0] lit;
    logic        ill;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [13:0] ins(input logic [2:0] op, input logic [2:0] r, input logic [7:0] imm);
    return {op, r, imm};
  endfunction

  function automatic logic [18:0] cwf(input logic [5:0] alu, input logic [2:0] r);
    return {alu, r, r, 7'b0000100};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [18:0] cw, input logic [15:0] lit, input logic ill);
    exp_t e;
    e.cw = cw; e.lit = lit; e.ill = ill;
    q.push_back(e);
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the instruction.
  task automatic issue(input logic [13:0] i);
    logic rdy;
    int   n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.instr    = i;
    do begin
      @(negedge clk);
      rdy = bus.in_ready && !flush;
      @(posedge clk);
      #1;
      n++;
    end while (!rdy && n < 50);
    bus.in_valid = 1'b0;
    if (!rdy) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout: instr %h not accepted in %0d cycles", i, n);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL out_unexpected: got cw=%b lit=%h ill=%b with empty scoreboard",
                 bus.cw_out, bus.lit_out, bus.illegal_out);
      end else begin
        exp_t e;
        e = q.pop_front();
        if (bus.cw_out !== e.cw || bus.lit_out !== e.lit || bus.illegal_out !== e.ill) begin
          errors++;
          $display("FAIL out_word: got cw=%b lit=%h ill=%b expected cw=%b lit=%h ill=%b",
                   bus.cw_out, bus.lit_out, bus.illegal_out, e.cw, e.lit, e.ill);
        end
      end
    end
  end

  initial begin
    bus.in_valid = 1'b0; bus.instr = '0; bus.out_ready = 1'b1;
    bus2.in_valid = 1'b0; bus2.instr = '0; bus2.out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_cw", 32'(bus.cw_out), 32'd0);
    chk("rst_lit", 32'(bus.lit_out), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_pending", 32'(pp), 32'd0);
    chk("rst_cnt", 32'(cnt), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Sign-extending instance: SUBI r0,#0xF0
    bus2.in_valid = 1'b1;
    bus2.instr    = ins(3'b010, 3'd0, 8'hF0);
    @(posedge clk); #1;
    bus2.in_valid = 1'b0;
    chk("sx_valid", 32'(bus2.out_valid), 32'd1);
    chk("sx_lit", 32'(bus2.lit_out), 32'h0000FFF0);
    chk("sx_cw", 32'(bus2.cw_out), 32'(cwf(6'b101101, 3'd0)));

    push(19'b1010010110110000100, 16'h002A, 1'b0);
    issue(ins(3'b001, 3'd3, 8'h2A));
    push(cwf(6'b101101, 3'd0), 16'h00F0, 1'b0);
    issue(ins(3'b010, 3'd0, 8'hF0));

    issue(ins(3'b100, 3'd0, 8'h12));
    chk("pfx_pending_set", 32'(pp), 32'd1);
    push(cwf(6'b011101, 3'd1), 16'h1234, 1'b0);
    issue(ins(3'b101, 3'd1, 8'h34));
    chk("pfx_pending_clr", 32'(pp), 32'd0);

    issue(ins(3'b100, 3'd0, 8'h56));
    push(19'd0, 16'hFFFF, 1'b0);
    issue(ins(3'b000, 3'd7, 8'hAA));
    chk("nop_keeps_pfx", 32'(pp), 32'd1);
    push(cwf(6'b001101, 3'd5), 16'h5678, 1'b0);
    issue(ins(3'b110, 3'd5, 8'h78));

    issue(ins(3'b100, 3'd0, 8'h77));
    push(19'd0, 16'h0000, 1'b1);
    issue(ins(3'b111, 3'd2, 8'h33));
    chk("ill_drops_pfx", 32'(pp), 32'd0);
    chk("ill_cnt_one", 32'(cnt), 32'd1);
    push(cwf(6'b101001, 3'd1), 16'h0005, 1'b0);
    issue(ins(3'b001, 3'd1, 8'h05));

    // Flush clears the prefix and drops the instruction presented alongside it.
    issue(ins(3'b100, 3'd0, 8'hAB));
    chk("flush_pre_pending", 32'(pp), 32'd1);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.instr = ins(3'b001, 3'd4, 8'h11);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    chk("flush_pending", 32'(pp), 32'd0);
    chk("flush_out_valid", 32'(bus.out_valid), 32'd0);
    push(cwf(6'b010001, 3'd2), 16'h000F, 1'b0);
    issue(ins(3'b011, 3'd2, 8'h0F));
    @(posedge clk); #1;

    // Stall with a waiting instruction, then release.
    bus.out_ready = 1'b0;
    push(cwf(6'b101001, 3'd6), 16'h003C, 1'b0);
    issue(ins(3'b001, 3'd6, 8'h3C));
    push(cwf(6'b011101, 3'd7), 16'h0001, 1'b0);
    bus.in_valid = 1'b1;
    bus.instr = ins(3'b101, 3'd7, 8'h01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
      chk("stall_cw", 32'(bus.cw_out), 32'(cwf(6'b101001, 3'd6)));
      chk("stall_lit", 32'(bus.lit_out), 32'h003C);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;

    for (int k = 0; k < 260; k++) begin
      push(19'd0, 16'h0000, 1'b1);
      issue(ins(3'b111, 3'(k), 8'(k)));
    end
    chk("cnt_saturated", 32'(cnt), 32'h000000FF);

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #1;

    // Reset while stalled.
    bus.out_ready = 1'b0;
    issue(ins(3'b110, 3'd5, 8'h55));
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst_cw", 32'(bus.cw_out), 32'd0);
    chk("midrst_lit", 32'(bus.lit_out), 32'd0);
    chk("midrst_cnt", 32'(cnt), 32'd0);
    chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // Reset discards a pending prefix.
    issue(ins(3'b100, 3'd0, 8'h99));
    chk("pre_rst_pending", 32'(pp), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_pending_lost", 32'(pp), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(cwf(6'b101001, 3'd0), 16'h0001, 1'b0);
    issue(ins(3'b001, 3'd0, 8'h01));

    for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
    #1;
    chk("scoreboard_empty", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
